mc_controller: RTL
==================

# mc_controller

Multi-cycle control FSM for the 8-bit CPU datapath. It sequences every instruction through fetch, decode, execute, memory and writeback steps. It drives the register-file addresses and write strobes (WE3, PCWrite, LRWrite), the ALU and multiplexer selects, and the memory strobes. It sits beside the register file and ALU and is the only source of their control inputs.

## Interface
- IMEM_WAIT_EN_DEFAULT, 1: reset value of the internal wait-enable bit; 0 ignores mem_ready and treats memory as single-cycle.
- CLK  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- Instr  input  16  instruction register contents: op[15:12], rd[11:9], rs1[8:6], rs2[5:3], imm6[5:0], imm8[7:0].
- Zero  input  1  registered zero flag from the datapath.
- mem_ready  input  1  memory handshake; the access completes in the cycle it is 1.
- IRWrite, MemRead, MemWrite, FlagWrite  output  1 each  strobes.
- WE3, PCWrite, LRWrite  output  1 each  register-file write strobes.
- A1, A2, A3  output  3 each  register-file addresses.
- AdrSrc  output  1  memory address source: 0 = PC, 1 = ALUOut.
- ALUSrcA  output  1  ALU operand A: 0 = RD1, 1 = PC.
- ALUSrcB  output  2  ALU operand B: 00 = RD2, 01 = sext imm6, 10 = 1, 11 = sext imm8.
- ALUControl  output  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- ResultSrc  output  2  WD3 source: 00 = ALUOut, 01 = MemData, 10 = PC, 11 = ALU result.
- halted, illegal  output  1 each  status outputs.

## Operation
- Opcodes:
  - 0–3: ADD/SUB/AND/ORR rd,rs1,rs2.
  - 4: ADDI rd,rs1,imm6.
  - 5: LDR rd,[rs1+imm6].
  - 6: STR rd,[rs1+imm6].
  - 7: B imm8.
  - 8: BEQ imm8.
  - 9: BL imm8.
  - 15: HALT.
  - All others are illegal.
- FETCH:
  - Drives A1=7, AdrSrc=0, MemRead=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=11.
  - Holds while mem_ready=0.
  - On mem_ready=1: IRWrite=1 and PCWrite=1, then goes to DECODE.
- DECODE: drives A1=rs1 and A2=rs2 (A2=rd for STR), then branches on op.
- EXEC_R: ALUSrcB=00, ALUControl=op[1:0], FlagWrite=1, then ALU_WB.
- EXEC_I: ALUSrcB=01, ADD, FlagWrite=1, then ALU_WB.
- MEMADR: ALUSrcB=01, ADD, then MEM_RD (LDR) or MEM_WR (STR).
- MEM_RD: AdrSrc=1, MemRead=1, holds until mem_ready, then MEM_WB.
- MEM_WR: AdrSrc=1, MemWrite=1, holds until mem_ready, then FETCH.
- ALU_WB / MEM_WB: A3=rd, WE3=1, ResultSrc=00 / 01, then FETCH. rd=7 is a legal jump.
- BRANCH (B, or BEQ with Zero=1):
  - ALUSrcA=1, ALUSrcB=11, ADD, ResultSrc=11, PCWrite=1, then FETCH.
  - BEQ with Zero=0 goes DECODE→FETCH with no write.
- LINK (BL only): LRWrite=1, ResultSrc=10, then BRANCH.
- HALT: halted=1; the FSM stays in HALT until reset.
- Illegal opcode: illegal pulses for one cycle in DECODE, then FETCH. No register write occurs.
- Invariants, checked every cycle:
  - At most one of WE3, PCWrite, LRWrite is 1.
  - MemRead and MemWrite are never both 1.
- Zero is sampled in DECODE only.

## Timing
- Reset (async assert):
  - State becomes FETCH.
  - All strobes, halted and illegal are 0.
  - A1=A2=A3=0; selects are 0.
- The first fetch starts on the first rising edge after reset deasserts.
- Reset asserted mid-instruction aborts it with no partial write.
- Outputs are a combinational decode of the registered state plus Instr/Zero/mem_ready (Moore, plus mem_ready gating of IRWrite/PCWrite).
- Cycle counts with mem_ready=1:
  - R, ADDI, STR: 4.
  - LDR: 5.
  - B, taken BEQ, BL with the macro off: 3.
  - BL with the macro on: 4.
  - Untaken BEQ, illegal: 2.
- Each mem_ready=0 cycle adds one cycle to the access state.
- mem_ready is sampled only in FETCH/MEM_RD/MEM_WR; it is ignored elsewhere.

## Configuration
- MCC_BRANCH_LINK_EN defined: BL goes DECODE→LINK→BRANCH and writes PC into r6.
- MCC_BRANCH_LINK_EN undefined:
  - LINK does not exist.
  - LRWrite is tied to 0.
  - Opcode 9 is decoded as B (no illegal pulse).

## Structure
- The shared package mcc_pkg holds:
  - the state encoding (FETCH … HALT);
  - opcode constants;
  - ALUControl, ALUSrcB and ResultSrc encodings;
  - the register indices REG_LR=6 and REG_PC=7.
- One sub-module, mcc_decode: a purely combinational state+Instr→control-output decoder. The FSM state register and next-state logic stay in mc_controller.

## Test plan
- Reset low mid-LDR, then released → next cycle is FETCH with A1=7 and MemRead=1, and no WE3 is seen.
- ADD r1,r2,r3 (0x0298) with mem_ready=1 → 4 cycles; ALU_WB has A3=1, WE3=1, ResultSrc=00.
- LDR r4,[r5+2] with mem_ready low for 3 cycles in MEM_RD → 8 cycles total; WE3 with A3=4 and ResultSrc=01 in the final cycle.
- BEQ imm8=0xFE, Zero=1 then Zero=0:
  - Zero=1: BRANCH with ALUSrcB=11 and PCWrite=1.
  - Zero=0: 2 cycles, no PCWrite after FETCH.
- BL with the macro on → LINK with LRWrite=1 and ResultSrc=10, then BRANCH.
- BL with the macro off → behaves as B; LRWrite stays 0.
- Opcode 0xA → illegal high for exactly 1 cycle.
- HALT → halted=1 held for 20 cycles until reset.
- All scenarios: at-most-one-of WE3/PCWrite/LRWrite asserted every cycle.

Source files
------------

// File: rtl/mcc_pkg.sv
// Shared types and encodings for the multi-cycle controller.
// MCC_BRANCH_LINK_EN adds the LINK state used by BL.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEMADR,
    S_MEM_RD,
    S_MEM_WR,
    S_ALU_WB,
    S_MEM_WB,
    S_BRANCH,
`ifdef MCC_BRANCH_LINK_EN
    S_LINK,
`endif
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LDR  = 4'd5;
  localparam logic [3:0] OP_STR  = 4'd6;
  localparam logic [3:0] OP_B    = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BL   = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM6 = 2'b01;
  localparam logic [1:0] SRCB_ONE  = 2'b10;
  localparam logic [1:0] SRCB_IMM8 = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_PC     = 2'b10;
  localparam logic [1:0] RES_ALU    = 2'b11;

  localparam logic [2:0] REG_LR = 3'd6;
  localparam logic [2:0] REG_PC = 3'd7;

  typedef struct packed {
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       flag_write;
    logic       we3;
    logic       pc_write;
    logic       lr_write;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] a3;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctl;
    logic [1:0] result_src;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_BL) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mcc_decode.sv
// Combinational state+Instr to control-strobe decoder.
// MCC_BRANCH_LINK_EN enables the LINK state outputs.
module mcc_decode
  import mcc_pkg::*;
(
  input  state_t      state,
  input  logic        active,
  input  logic [15:0] instr,
  input  logic        rdy,
  output ctrl_t       ctrl
);

  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic       unused_imm;

  assign op  = instr[15:12];
  assign rd  = instr[11:9];
  assign rs1 = instr[8:6];
  assign rs2 = instr[5:3];
  // immediate low bits feed the datapath, not the controller
  assign unused_imm = ^instr[2:0];

  always_comb begin
    ctrl = '0;
    if (active) begin
      ctrl.a1 = rs1;
      ctrl.a2 = (op == OP_STR) ? rd : rs2;
      unique case (state)
        S_FETCH: begin
          ctrl.a1         = REG_PC;
          ctrl.a3         = REG_PC;
          ctrl.mem_read   = 1'b1;
          ctrl.alu_src_a  = 1'b1;
          ctrl.alu_src_b  = SRCB_ONE;
          ctrl.alu_ctl    = ALU_ADD;
          ctrl.result_src = RES_ALU;
          ctrl.ir_write   = rdy;
          ctrl.pc_write   = rdy;
        end
        S_DECODE: ctrl.illegal = !op_legal(op);
        S_EXEC_R: begin
          ctrl.alu_src_b  = SRCB_RD2;
          ctrl.alu_ctl    = op[1:0];
          ctrl.flag_write = 1'b1;
        end
        S_EXEC_I: begin
          ctrl.alu_src_b  = SRCB_IMM6;
          ctrl.alu_ctl    = ALU_ADD;
          ctrl.flag_write = 1'b1;
        end
        S_MEMADR: begin
          ctrl.alu_src_b = SRCB_IMM6;
          ctrl.alu_ctl   = ALU_ADD;
        end
        S_MEM_RD: begin
          ctrl.adr_src  = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.adr_src   = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        S_ALU_WB: begin
          ctrl.a3         = rd;
          ctrl.we3        = 1'b1;
          ctrl.result_src = RES_ALUOUT;
        end
        S_MEM_WB: begin
          ctrl.a3         = rd;
          ctrl.we3        = 1'b1;
          ctrl.result_src = RES_MEM;
        end
        S_BRANCH: begin
          ctrl.a3         = REG_PC;
          ctrl.alu_src_a  = 1'b1;
          ctrl.alu_src_b  = SRCB_IMM8;
          ctrl.alu_ctl    = ALU_ADD;
          ctrl.result_src = RES_ALU;
          ctrl.pc_write   = 1'b1;
        end
`ifdef MCC_BRANCH_LINK_EN
        S_LINK: begin
          ctrl.a3         = REG_LR;
          ctrl.lr_write   = 1'b1;
          ctrl.result_src = RES_PC;
        end
`endif
        S_HALT: ctrl.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the 8-bit CPU datapath.
// Define MCC_BRANCH_LINK_EN to make BL link through r6.
module mc_controller
  import mcc_pkg::*;
#(
  parameter bit IMEM_WAIT_EN_DEFAULT = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        FlagWrite,
  output logic        WE3,
  output logic        PCWrite,
  output logic        LRWrite,
  output logic [2:0]  A1,
  output logic [2:0]  A2,
  output logic [2:0]  A3,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic        halted,
  output logic        illegal
);

  state_t     state;
  state_t     state_n;
  logic       wait_en;
  logic       rdy;
  logic [3:0] op;
  ctrl_t      ctrl;

  assign op  = Instr[15:12];
  assign rdy = !wait_en || mem_ready;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      wait_en <= IMEM_WAIT_EN_DEFAULT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:  if (rdy) state_n = S_DECODE;
      S_DECODE: begin
        state_n = S_FETCH;
        unique case (1'b1)
          op[3:2] == 2'b00: state_n = S_EXEC_R;
          op == OP_ADDI:    state_n = S_EXEC_I;
          op == OP_LDR:     state_n = S_MEMADR;
          op == OP_STR:     state_n = S_MEMADR;
          op == OP_B:       state_n = S_BRANCH;
          op == OP_BEQ:     state_n = Zero ? S_BRANCH : S_FETCH;
`ifdef MCC_BRANCH_LINK_EN
          op == OP_BL:      state_n = S_LINK;
`else
          op == OP_BL:      state_n = S_BRANCH;
`endif
          op == OP_HALT:    state_n = S_HALT;
          default: ;
        endcase
      end
      S_EXEC_R: state_n = S_ALU_WB;
      S_EXEC_I: state_n = S_ALU_WB;
      S_MEMADR: state_n = (op == OP_LDR) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (rdy) state_n = S_MEM_WB;
      S_MEM_WR: if (rdy) state_n = S_FETCH;
      S_ALU_WB: state_n = S_FETCH;
      S_MEM_WB: state_n = S_FETCH;
      S_BRANCH: state_n = S_FETCH;
`ifdef MCC_BRANCH_LINK_EN
      S_LINK:   state_n = S_BRANCH;
`endif
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_FETCH;
    endcase
  end

  mcc_decode u_decode (
    .state  (state),
    .active (reset),
    .instr  (Instr),
    .rdy    (rdy),
    .ctrl   (ctrl)
  );

  assign IRWrite    = ctrl.ir_write;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign FlagWrite  = ctrl.flag_write;
  assign WE3        = ctrl.we3;
  assign PCWrite    = ctrl.pc_write;
  assign LRWrite    = ctrl.lr_write;
  assign A1         = ctrl.a1;
  assign A2         = ctrl.a2;
  assign A3         = ctrl.a3;
  assign AdrSrc     = ctrl.adr_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUControl = ctrl.alu_ctl;
  assign ResultSrc  = ctrl.result_src;
  assign halted     = ctrl.halted;
  assign illegal    = ctrl.illegal;

endmodule
